// File: rtl/fixp_expander_if.sv
// Stream bundle for the fixed-point expander: narrow input side and wide output side.
// The master modport is the environment (producer and consumer). The slave modport is the expander.
`timescale 1ns/1ps

interface fixp_expander_if #(
    parameter int NARROW_W = 16,
    parameter int WIDE_W   = 24
);
    logic                fmt_sm;
    logic                in_valid;
    logic                in_ready;
    logic [NARROW_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDE_W-1:0]   out_data;
    logic                out_err;

    modport master (
        output fmt_sm, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  fmt_sm, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/fixp_expander.sv
// Re-expands a narrow rounded fixed-point sample to the wide internal format.
// Input may be sign-magnitude or two's complement (selected per beat). Output is two's complement
// with FRAC_BITS zero fractional bits appended. Three-stage pipeline with one global advance enable.
`timescale 1ns/1ps

module fixp_expander #(
    parameter int NARROW_W  = 16,
    parameter int FRAC_BITS = 7,
    parameter int WIDE_W    = 24,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_b,
    fixp_expander_if.slave   bus,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
);

    // Reject configurations where the shifted, sign-extended value could not fit.
    if (FRAC_BITS < 1) begin : g_bad_frac
        $error("fixp_expander: FRAC_BITS must be >= 1");
    end
    if (WIDE_W < NARROW_W + FRAC_BITS) begin : g_bad_width
        $error("fixp_expander: WIDE_W must be >= NARROW_W + FRAC_BITS");
    end

    localparam logic [NARROW_W-1:0] ONE_N   = NARROW_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

    // All stages move together. A stall anywhere freezes the whole pipe.
    logic en;
    assign en          = bus.out_ready | ~bus.out_valid;
    // NOTE: in_ready is a combinational function of the output side. Registering it would lose a beat
    // on the first stall cycle, because the upstream would already have presented that beat.
    assign bus.in_ready = en;

    // Classify the incoming code. Only a sign bit with an all-zero body is special.
    logic in_body_zero;
    logic in_neg_zero;
    logic in_illegal;
    assign in_body_zero = ~|bus.in_data[NARROW_W-2:0];
    assign in_neg_zero  =  bus.fmt_sm & bus.in_data[NARROW_W-1] & in_body_zero;
    assign in_illegal   = ~bus.fmt_sm & bus.in_data[NARROW_W-1] & in_body_zero;

    // Stage 1 state
    logic                s1_valid;
    logic [NARROW_W-1:0] s1_data;
    logic                s1_sm;
    logic                s1_zero;
    logic                s1_err;

    // Stage 2 state
    logic                s2_valid;
    logic [WIDE_W-1:0]   s2_val;
    logic                s2_err;

    // Stage 1: capture the raw sample, its format and the zero/illegal classification.
    // NOTE: every register here is written with <= so all stages read the values from before the edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sm    <= 1'b0;
            s1_zero  <= 1'b0;
            s1_err   <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_data  <= bus.in_data;
            s1_sm    <= bus.fmt_sm;
            s1_zero  <= in_neg_zero;
            s1_err   <= in_illegal;
        end
    end

    // Convert a negative sign-magnitude value to two's complement. Then sign-extend to the wide width.
    logic [NARROW_W-1:0] s1_mag_ext;
    logic [NARROW_W-1:0] s1_twos;
    logic [WIDE_W-1:0]   s1_wide;
    always_comb begin
        s1_mag_ext = {1'b0, s1_data[NARROW_W-2:0]};
        s1_twos    = s1_data;
        if (s1_sm && s1_data[NARROW_W-1]) begin
            s1_twos = ~s1_mag_ext + ONE_N;
        end
        s1_wide = {{(WIDE_W-NARROW_W){s1_twos[NARROW_W-1]}}, s1_twos};
    end

    // Stage 2: hold the canonical wide value. Zero codes collapse to a single +0.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s2_valid <= 1'b0;
            s2_val   <= '0;
            s2_err   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_val   <= (s1_zero || s1_err) ? '0 : s1_wide;
            s2_err   <= s1_err;
        end
    end

    // Stage 3: restore the fractional bits and force illegal beats to zero with the error flag set.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_err   <= 1'b0;
        end else if (en) begin
            bus.out_valid <= s2_valid;
            bus.out_data  <= s2_err ? '0 : {s2_val[WIDE_W-FRAC_BITS-1:0], {FRAC_BITS{1'b0}}};
            bus.out_err   <= s2_err;
        end
    end

    // Count illegal beats as they are delivered. The count saturates, and a clear overrides a same-cycle count.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fixp_expander.sv
// Directed bench for fixp_expander: reset, conversion values, zero codes, streaming stall,
// error counter saturation and clear, and reset with beats in flight.
`timescale 1ns/1ps

module tb_fixp_expander;

    // A narrow counter makes saturation reachable in a short run.
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_b;
    logic [CNT_W-1:0] err_cnt;
    logic             err_cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    fixp_expander_if #(.NARROW_W(16), .WIDE_W(24)) bus ();

    fixp_expander #(
        .NARROW_W (16),
        .FRAC_BITS(7),
        .WIDE_W   (24),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .bus        (bus),
        .err_cnt    (err_cnt),
        .err_cnt_clr(err_cnt_clr)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end before limit");
        $fatal(1, "watchdog");
    end

    // Drive one beat with an idle pipe and return the output and the cycles until out_valid.
    // On return, it is just after a falling edge with out_valid high and the beat not yet consumed.
    task automatic single_beat(input logic [15:0] d, input logic sm,
                               output logic [23:0] od, output logic oe, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.fmt_sm    = sm;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        od = bus.out_data;
        oe = bus.out_err;
    endtask

    task automatic test_reset();
        reset_b       = 1'b0;
        err_cnt_clr   = 1'b0;
        bus.fmt_sm    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data: got %h required 000000", bus.out_data); end
        n_checks++;
        if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b required 0", bus.out_err); end
        n_checks++;
        if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d required 0", err_cnt); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_convert();
        logic [15:0] vin [7];
        logic        vsm [7];
        logic [23:0] vexp[7];
        logic [23:0] od;
        logic        oe;
        int          lat;
        vin  = '{16'h0005, 16'hFFFB, 16'h8005, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h8001};
        vsm  = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0};
        vexp = '{24'h000280, 24'hFFFD80, 24'hFFFD80, 24'h000280, 24'h3FFF80, 24'hC00080, 24'hC00080};
        for (int i = 0; i < 7; i++) begin
            single_beat(vin[i], vsm[i], od, oe, lat);
            n_checks++;
            if (lat !== 3) begin n_fail++; $display("FAIL convert_latency[%0d]: got %0d required 3", i, lat); end
            n_checks++;
            if (od !== vexp[i]) begin n_fail++; $display("FAIL convert_data[%0d] in=%h sm=%b: got %h required %h", i, vin[i], vsm[i], od, vexp[i]); end
            n_checks++;
            if (oe !== 1'b0) begin n_fail++; $display("FAIL convert_err[%0d]: got %b required 0", i, oe); end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_codes();
        logic [23:0] od;
        logic        oe;
        int          lat;
        // Sign-magnitude negative zero: legal and canonicalised
        single_beat(16'h8000, 1'b1, od, oe, lat);
        n_checks++;
        if (od !== 24'h0) begin n_fail++; $display("FAIL sm_neg_zero_data: got %h required 000000", od); end
        n_checks++;
        if (oe !== 1'b0) begin n_fail++; $display("FAIL sm_neg_zero_err: got %b required 0", oe); end
        @(negedge clk);
        n_checks++;
        if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL sm_neg_zero_cnt: got %0d required 0", err_cnt); end
        // Two's-complement most-negative code: illegal
        single_beat(16'h8000, 1'b0, od, oe, lat);
        n_checks++;
        if (od !== 24'h0) begin n_fail++; $display("FAIL tc_illegal_data: got %h required 000000", od); end
        n_checks++;
        if (oe !== 1'b1) begin n_fail++; $display("FAIL tc_illegal_err: got %b required 1", oe); end
        n_checks++;
        if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL tc_illegal_cnt_before: got %0d required 0", err_cnt); end
        @(negedge clk);
        n_checks++;
        if (err_cnt !== 4'd1) begin n_fail++; $display("FAIL tc_illegal_cnt_after: got %0d required 1", err_cnt); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [15:0] vec [8];
        logic [23:0] vexp[8];
        logic [23:0] held;
        int          sent;
        int          rx;
        vec  = '{16'h0001, 16'h0002, 16'hFFFF, 16'h0010, 16'h0100, 16'hFF00, 16'h1234, 16'h7FFF};
        vexp = '{24'h000080, 24'h000100, 24'hFFFF80, 24'h000800, 24'h008000, 24'hFF8000, 24'h091A00, 24'h3FFF80};
        sent = 0;
        rx   = 0;
        held = '0;
        bus.fmt_sm = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vec[sent];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            #1;
            if (!bus.out_ready) begin
                n_checks++;
                if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc%0d: got %b required 0", cyc, bus.in_ready); end
                if (cyc == 6) begin
                    held = bus.out_data;
                end else begin
                    n_checks++;
                    if (bus.out_data !== held) begin n_fail++; $display("FAIL stall_hold cyc%0d: got %h required %h", cyc, bus.out_data, held); end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (rx >= 8) begin
                    n_fail++;
                    $display("FAIL stream_extra: got beat %h after 8 beats, required no more beats", bus.out_data);
                end else if (bus.out_data !== vexp[rx]) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got %h required %h", rx, bus.out_data, vexp[rx]);
                end
                rx++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        n_checks++;
        if (rx !== 8) begin n_fail++; $display("FAIL stream_count: got %0d beats required 8", rx); end
        n_checks++;
        if (sent !== 8) begin n_fail++; $display("FAIL stream_accepted: got %0d accepted required 8", sent); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_err_saturation();
        logic [23:0] od;
        logic        oe;
        int          lat;
        // Counter currently holds 1, so 20 more illegal beats must stop at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_data   = 16'h8000;
            bus.fmt_sm    = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (err_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d required 15", err_cnt); end
        single_beat(16'h8000, 1'b0, od, oe, lat);
        @(negedge clk);
        n_checks++;
        if (err_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d required 15", err_cnt); end
        // Clear in the same cycle as an illegal beat transfer
        single_beat(16'h8000, 1'b0, od, oe, lat);
        err_cnt_clr = 1'b1;
        @(negedge clk);
        err_cnt_clr = 1'b0;
        n_checks++;
        if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_wins: got %0d required 0", err_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        int seen;
        bus.out_ready = 1'b0;
        bus.fmt_sm    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0011 * 16'(i + 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_filled: got %b required 1", bus.out_valid); end
        reset_b = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== 24'h0) begin n_fail++; $display("FAIL midrst_data: got %h required 000000", bus.out_data); end
        @(negedge clk);
        reset_b       = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d beats required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_zero_codes();
        test_stream();
        test_err_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
